// File: rtl/axi_rd_slave_mem.sv
// AXI4 read-channel slave backed by a word-addressed RAM with a backdoor preload port.
// Serves FIXED/INCR/WRAP bursts at one beat per cycle after a fixed start latency.
module axi_rd_slave_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LATENCY  = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [31:0]                    s_axi_araddr,
    input  logic [1:0]                     s_axi_arburst,
    input  logic [3:0]                     s_axi_arid,
    input  logic [7:0]                     s_axi_arlen,
    input  logic [2:0]                     s_axi_arsize,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [3:0]                     s_axi_rid,
    output logic [31:0]                    s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rlast,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    input  logic                           init_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
    input  logic [31:0]                    init_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

    typedef struct packed {
        logic [29:0] start;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [1:0]  burst;
        logic        slverr;
    } cmd_t;

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    cmd_t        cmd_q, ar_cmd, cur_cmd;
    logic [7:0]  beat_q, ld_k;
    logic        arready_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;
    logic [3:0]  rid_q;

    logic        ar_hs, r_hs;
    logic        load_first, load_next, load;
    logic [29:0] wrap_mask, lin_word, word;
    logic        out_of_range;
    logic [AW-1:0] ram_idx;
    logic [31:0] ram_word;
    logic [31:0] beat_data;
    logic [1:0]  beat_resp;

    logic [31:0] mem [DEPTH_WORDS];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^s_axi_araddr[1:0];

    assign ar_hs = s_axi_arvalid & arready_q;
    assign r_hs  = s_axi_rvalid & s_axi_rready;

    // Decode the incoming request; WRAP is only defined for 2, 4, 8 or 16 beats.
    always_comb begin
        ar_cmd.start  = s_axi_araddr[31:2];
        ar_cmd.len    = s_axi_arlen;
        ar_cmd.id     = s_axi_arid;
        ar_cmd.burst  = s_axi_arburst;
        ar_cmd.slverr = (s_axi_arburst == 2'b11) || (s_axi_arsize != 3'b010) ||
                        ((s_axi_arburst == BURST_WRAP) &&
                         !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    // NOTE: every signal written in an always_comb gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    lat_d = LAT_INIT;
                    if (RD_LATENCY == 1) begin
                        state_d    = ST_BURST;
                        load_first = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    state_d    = ST_BURST;
                    load_first = 1'b1;
                end
            end
            ST_BURST: begin
                if (r_hs) begin
                    if (rlast_q) state_d = ST_IDLE;
                    else         load_next = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load = load_first | load_next;

    // With single-cycle latency the first beat is fetched on the AR handshake edge itself,
    // before the command register has been written, so take the command straight from the bus.
    assign cur_cmd = (state_q == ST_IDLE) ? ar_cmd : cmd_q;
    assign ld_k    = load_first ? 8'd0 : beat_q + 8'd1;

    always_comb begin
        wrap_mask = {22'd0, cur_cmd.len};
        lin_word  = cur_cmd.start + {22'd0, ld_k};
        case (cur_cmd.burst)
            BURST_FIXED: word = cur_cmd.start;
            BURST_WRAP:  word = (cur_cmd.start & ~wrap_mask) | (lin_word & wrap_mask);
            default:     word = lin_word;
        endcase
    end

    assign out_of_range = (word >> AW) != 30'd0;
    assign ram_idx      = word[AW-1:0];

    // A backdoor write landing on the edge that fetches a beat is forwarded, so the beat
    // fetched on that edge already sees the new word; beats fetched earlier keep old data.
    assign ram_word = (init_we && (init_addr == ram_idx)) ? init_data : mem[ram_idx];

    always_comb begin
        beat_resp = RESP_OKAY;
        beat_data = ram_word;
        if (cur_cmd.slverr) begin
            beat_resp = RESP_SLVERR;
            beat_data = 32'd0;
        end else if (out_of_range) begin
            beat_resp = RESP_DECERR;
            beat_data = 32'd0;
        end
    end

    // NOTE: the RAM array has no reset; preload happens through the backdoor port and
    // clearing thousands of words on reset would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            lat_q     <= 4'd0;
            arready_q <= 1'b0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            arready_q <= (state_d == ST_IDLE);
            if (ar_hs) cmd_q <= ar_cmd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q  <= 8'd0;
            rdata_q <= 32'd0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
            rid_q   <= 4'd0;
        end else if (load) begin
            beat_q  <= ld_k;
            rdata_q <= beat_data;
            rresp_q <= beat_resp;
            rlast_q <= (ld_k == cur_cmd.len);
            rid_q   <= cur_cmd.id;
        end else if (state_d != ST_BURST) begin
            rlast_q <= 1'b0;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (state_q == ST_BURST);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;

endmodule
